// File: rtl/mdu_seq_engine_pkg.sv
// mdu_seq_engine_pkg: op encodings, FSM states and MIPS funct codes shared by the MDU and its users
package mdu_seq_engine_pkg;
    localparam logic [1:0] MDU_OP_MULT  = 2'b00;
    localparam logic [1:0] MDU_OP_DIV   = 2'b01;
    localparam logic [1:0] MDU_OP_MULTU = 2'b10;
    localparam logic [1:0] MDU_OP_DIVU  = 2'b11;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    typedef enum logic [1:0] {MDU_S_IDLE, MDU_S_CALC, MDU_S_FIX, MDU_S_DONE} mdu_state_e;
    function automatic logic [1:0] mdu_funct_op(input logic [5:0] f);
        return f == F_DIV ? MDU_OP_DIV : f == F_MULTU ? MDU_OP_MULTU : f == F_DIVU ? MDU_OP_DIVU : MDU_OP_MULT;
    endfunction
endpackage

// File: rtl/mdu_seq_engine_if.sv
// mdu_seq_engine_if: start/done handshake and HI/LO result bus between the CPU and the MDU
interface mdu_seq_engine_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;
    modport master (output start, op, a, b, input busy, done, hi, lo, div_zero);
    modport slave (input start, op, a, b, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/mdu_seq_engine_abs_neg.sv
// mdu_abs_neg: conditional two's-complement, used for operand magnitude and result sign fix
module mdu_abs_neg #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/mdu_seq_engine.sv
// mdu_seq_engine: iterative MULT/DIV on magnitudes with a final sign fix, one bit per cycle.
// Define MDU_UNSIGNED_EN to make op[1] select MULTU/DIVU; otherwise op[1] is ignored.
module mdu_seq_engine import mdu_seq_engine_pkg::*; #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic reset,
    mdu_seq_engine_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    mdu_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, sr_q, sr_d, bv_q, bv_d, hi_q, hi_d, lo_q, lo_d;
    logic div_q, div_d, nh_q, nh_d, nl_q, nl_d, dz_q, dz_d;
    logic idle, sgn, sa, sb, is_div, div0;
    logic [WIDTH-1:0] ua, ub;
    logic [2*WIDTH-1:0] up;
    logic [WIDTH:0] sum, rem_t, diff;

    assign idle = state_q == MDU_S_IDLE;
`ifdef MDU_UNSIGNED_EN
    assign sgn = !bus.op[1];
`else
    assign sgn = 1'b1;
`endif
    assign sa = sgn & bus.a[WIDTH-1];
    assign sb = sgn & bus.b[WIDTH-1];
    assign is_div = bus.op inside {MDU_OP_DIV, MDU_OP_DIVU};
    assign div0 = is_div && bus.b == '0;
    assign sum = {1'b0, acc_q} + (sr_q[0] ? {1'b0, bv_q} : '0);
    assign rem_t = {acc_q, sr_q[WIDTH-1]};
    assign diff = rem_t - {1'b0, bv_q};

    // The word negators take operands in IDLE and the quotient/remainder in FIX
    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.x(idle ? bus.a : acc_q), .neg(idle ? sa : nh_q), .y(ua));
    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.x(idle ? bus.b : sr_q), .neg(idle ? sb : nl_q), .y(ub));
    mdu_abs_neg #(.WIDTH(2*WIDTH)) u_neg_p (.x({acc_q, sr_q}), .neg(nl_q), .y(up));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MDU_S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sr_q    <= '0;
            bv_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            nh_q    <= 1'b0;
            nl_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            bv_q    <= bv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            nh_q    <= nh_d;
            nl_q    <= nl_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MDU_S_IDLE: if (bus.start) state_d = div0 ? MDU_S_DONE : MDU_S_CALC;
            MDU_S_CALC: if (cnt_q == '0) state_d = MDU_S_FIX;
            MDU_S_FIX:  state_d = MDU_S_DONE;
            default:    state_d = MDU_S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        sr_d  = sr_q;
        bv_d  = bv_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        div_d = div_q;
        nh_d  = nh_q;
        nl_d  = nl_q;
        dz_d  = dz_q;
        if (idle && bus.start) begin
            cnt_d = CW'(WIDTH - 1);
            acc_d = '0;
            sr_d  = ua;
            bv_d  = ub;
            div_d = is_div;
            nh_d  = is_div ? sa : sa ^ sb;
            nl_d  = sa ^ sb;
            dz_d  = div0;
            hi_d  = div0 ? bus.a : hi_q;
            lo_d  = div0 ? '1 : lo_q;
        end else if (state_q == MDU_S_CALC) begin
            cnt_d = cnt_q - 1'b1;
            // Mult shifts {acc,sr} right after a conditional add; div shifts left restoring on borrow
            acc_d = div_q ? (diff[WIDTH] ? rem_t[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
            sr_d  = div_q ? {sr_q[WIDTH-2:0], !diff[WIDTH]} : {sum[0], sr_q[WIDTH-1:1]};
        end else if (state_q == MDU_S_FIX) begin
            hi_d = div_q ? ua : up[2*WIDTH-1:WIDTH];
            lo_d = div_q ? ub : up[WIDTH-1:0];
        end
    end

    assign bus.busy     = state_q inside {MDU_S_CALC, MDU_S_FIX};
    assign bus.done     = state_q == MDU_S_DONE;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_mdu_seq_engine.sv
// tb_mdu_seq_engine: random and directed MULT/DIV traffic checked every cycle against an arithmetic model
module tb_mdu_seq_engine;
    import mdu_seq_engine_pkg::*;
    localparam int W = 32;
    logic clk = 1'b0;
    logic reset;
    int cyc = 0, ntest = 0, nfail = 0;
    int lat, bc, ndone;
    bit pend = 1'b0;
    int st_c, due;
    logic [W-1:0] cur_hi, cur_lo, nx_hi, nx_lo;
    logic cur_dz, nx_dz;
    logic [1:0] mult_op, div_op;

    mdu_seq_engine_if #(.WIDTH(W)) bus ();
    mdu_seq_engine #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic uns;
        longint x, y, q, r;
        uns = 1'b0;
`ifdef MDU_UNSIGNED_EN
        uns = op[1];
`endif
        if (uns) begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end else begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end
        if (!op[0]) begin
            q = x * y;
            return {1'b0, q};
        end
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        q = x / y;
        r = x % y;
        return {1'b0, r[W-1:0], q[W-1:0]};
    endfunction

    always @(negedge clk) begin
        bit acc;
        if (!reset) begin
            pend = 1'b0;
            cur_hi = '0;
            cur_lo = '0;
            cur_dz = 1'b0;
            chk("reset_hilo", {bus.hi, bus.lo}, 64'h0);
            chk("reset_flags", {bus.busy, bus.done, bus.div_zero}, 64'h0);
        end else begin
            acc = bus.start && !pend;
            if (pend && cyc == st_c + 1) cur_dz = nx_dz;
            if (pend && cyc == due) begin
                cur_hi = nx_hi;
                cur_lo = nx_lo;
            end
            chk("done", bus.done, pend && cyc == due);
            chk("busy", bus.busy, pend && cyc > st_c && cyc < due);
            chk("hi", bus.hi, cur_hi);
            chk("lo", bus.lo, cur_lo);
            chk("div_zero", bus.div_zero, cur_dz);
            if (pend && cyc == due) pend = 1'b0;
            if (acc) begin
                {nx_dz, nx_hi, nx_lo} = model(bus.op, bus.a, bus.b);
                st_c = cyc;
                due = cyc + ((bus.op[0] && bus.b == '0) ? 1 : W + 2);
                pend = 1'b1;
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op = 2'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    task automatic wait_done(input bit noise, output int l, output int bcount);
        l = 1;
        bcount = 0;
        while (!bus.done && l < 100) begin
            bcount += int'(bus.busy);
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.op = 2'($urandom);
                bus.a = $urandom;
                bus.b = $urandom;
            end
            @(posedge clk); #1;
            l++;
        end
        bus.start = 1'b0;
        if (!bus.done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [W-1:0] pick();
        int k;
        k = $urandom_range(0, 5);
        return k == 0 ? 32'h8000_0000 : k == 1 ? 32'hFFFF_FFFF : k == 2 ? 32'($urandom_range(0, 15)) : 32'($urandom);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mult_op = mdu_funct_op(F_MULT);
        div_op = mdu_funct_op(F_DIV);
        reset = 1'b0;
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_hilo", {bus.hi, bus.lo}, 64'h0);
        chk("init_flags", {bus.busy, bus.done, bus.div_zero}, 64'h0);
        reset = 1'b1;

        drive(mult_op, 32'd7, 32'hFFFF_FFFD);
        wait_done(1'b0, lat, bc);
        chk("mult_lat", lat, 34);
        chk("mult_busy_cycles", bc, 33);
        chk("mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_dz", bus.div_zero, 1'b0);

        drive(div_op, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, lat, bc);
        chk("div_neg_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("div_neg_dz", bus.div_zero, 1'b0);

        drive(div_op, 32'd5, 32'd0);
        wait_done(1'b0, lat, bc);
        chk("div0_lat", lat, 1);
        chk("div0_hilo", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
        chk("div0_flag", bus.div_zero, 1'b1);
        drive(mult_op, 32'd3, 32'd4);
        chk("div0_cleared", bus.div_zero, 1'b0);
        wait_done(1'b0, lat, bc);
        chk("mult_small_hilo", {bus.hi, bus.lo}, 64'd12);

        ndone = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            bus.start = 1'b1;
            bus.op = mult_op;
            bus.a = 32'h8000_0000;
            bus.b = 32'h8000_0000;
            if (bus.done) begin
                ndone++;
                chk("spam_hilo", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("spam_one_done", ndone, 1);
        chk("spam_restart_busy", bus.busy, 1'b1);
        wait_done(1'b0, lat, bc);
        chk("spam_second_hilo", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

        drive(div_op, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_hilo", {bus.hi, bus.lo}, 64'h0);
        chk("abort_flags", {bus.busy, bus.done, bus.div_zero}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            ndone += int'(bus.done);
        end
        chk("abort_no_done", ndone, 0);
        drive(div_op, 32'd100, 32'd7);
        wait_done(1'b0, lat, bc);
        chk("div_100_7_hilo", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

        drive(mdu_funct_op(F_MULTU), 32'hFFFF_FFFF, 32'd2);
        wait_done(1'b0, lat, bc);
`ifdef MDU_UNSIGNED_EN
        chk("multu_hilo", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
`else
        chk("multu_as_mult_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
`endif

        drive(div_op, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, lat, bc);
        chk("div_min_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        chk("div_min_dz", bus.div_zero, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [1:0] rop;
            logic [W-1:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? '0 : pick();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            drive(rop, ra, rb);
            wait_done(1'b1, lat, bc);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
